// File: rtl/fetch_mrx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_mrx_pkg
// Description : Shared constants, state encodings and helpers for the
//               multi-channel fetch receiver (fetch_mrx / fetch_rx_ch).
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
package fetch_mrx_pkg;

    // First byte of every frame.
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    // Bit value replicated across a word when a channel times out.
    localparam logic        FILL_BIT = 1'b1;

    // Shortest usable bit period; smaller programmed values are raised to this.
    localparam logic [19:0] TBIT_MIN = 20'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_WAIT = 3'd2,
        ST_BYTE = 3'd3,
        ST_DONE = 3'd4
    } pkt_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2
    } rx_state_t;

    function automatic logic [19:0] clamp_tbit(input logic [19:0] p);
        return (p < TBIT_MIN) ? TBIT_MIN : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_rx_ch.sv
`default_nettype none
// ============================================================================
// Module      : fetch_rx_ch
// Description : One asynchronous serial receiver: 2-FF synchroniser,
//               start-bit qualification, mid-bit sampling, LSB-first shift
//               register and stop-bit check.
// Ports       : clk_sys, rst_n   - clock / async active-low reset
//               tbit_period_i    - clk_sys cycles per bit (clamped to >= 4)
//               rx_i             - raw serial line, idle high
//               word_done_o      - one-cycle pulse, word_o valid that cycle
//               word_o           - last received word
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module fetch_rx_ch
    import fetch_mrx_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic [19:0]       tbit_period_i,
    input  logic              rx_i,
    output logic              word_done_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int BCW = $clog2(WORD_W + 1);

    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t         st_q;
    logic [19:0]       cnt_q;
    logic [BCW-1:0]    bit_q;
    logic [WORD_W-1:0] shift_q;
    logic              done_q;

    logic [19:0]       w_tbit;
    logic [19:0]       w_half;

    assign w_tbit = clamp_tbit(tbit_period_i);
    assign w_half = {1'b0, w_tbit[19:1]};

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            st_q      <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            done_q    <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        st_q  <= RX_START;
                        cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit after the edge: still low means a real start.
                    if (cnt_q == w_half - 20'd1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == w_tbit - 20'd1) begin
                        cnt_q <= '0;
                        if (bit_q == BCW'(WORD_W)) begin
                            // Stop bit: low is a framing error, word silently dropped.
                            done_q <= rx_s2_q;
                            st_q   <= RX_IDLE;
                        end else begin
                            shift_q <= {rx_s2_q, shift_q[WORD_W-1:1]};
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

    assign word_done_o = done_q;
    assign word_o      = shift_q;

endmodule
`default_nettype wire

// File: rtl/fetch_mrx.sv
`default_nettype none
// ============================================================================
// Module      : fetch_mrx
// Description : NCH-channel serial receiver with one-word holding buffers and
//               a packetizer that emits A5 followed by len_pkg words from each
//               enabled channel (MSB byte first) per fire_sync.
// Ports       : clk_sys, rst_n        - clock / async active-low reset
//               fire_sync             - frame start pulse (honoured in IDLE)
//               tbit_period, len_pkg  - bit period, words per channel
//               ch_en, rx             - channel mask, serial lines
//               pkg_data/vld/frm      - framed byte stream
//               ovf_flag, tmo_flag    - sticky per-channel flags
//               flag_clr              - clears both flag vectors
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module fetch_mrx
    import fetch_mrx_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int WORD_W  = 16,
    parameter int TMO_CYC = 1000000
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           fire_sync,
    input  logic [19:0]    tbit_period,
    input  logic [15:0]    len_pkg,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] rx,
    output logic [7:0]     pkg_data,
    output logic           pkg_vld,
    output logic           pkg_frm,
    output logic [NCH-1:0] ovf_flag,
    output logic [NCH-1:0] tmo_flag,
    input  logic           flag_clr
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NB  = WORD_W / 8;
    localparam int BCW = $clog2(NB + 1);

    logic [NCH-1:0]    w_done;
    logic [WORD_W-1:0] w_word [NCH];

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            fetch_rx_ch #(.WORD_W(WORD_W)) u_rx (
                .clk_sys       (clk_sys),
                .rst_n         (rst_n),
                .tbit_period_i (tbit_period),
                .rx_i          (rx[g]),
                .word_done_o   (w_done[g]),
                .word_o        (w_word[g])
            );
        end
    endgenerate

    logic [WORD_W-1:0] buf_q [NCH];
    logic [NCH-1:0]    bvld_q, ovf_q, tmo_q;

    pkt_state_t        st_q;
    logic [7:0]        data_q;
    logic              vld_q, frm_q;
    logic [NCH-1:0]    mask_q;
    logic [15:0]       len_q, widx_q;
    logic [CHW-1:0]    ch_q;
    logic [31:0]       tmo_cnt_q;
    logic [WORD_W-1:0] word_q;
    logic [BCW-1:0]    bcnt_q;

    logic              w_hit, w_tmo;
    logic [NCH-1:0]    w_consume, w_tmo_set, w_ovf_set;
    logic [WORD_W-1:0] w_cap;
    logic [CHW-1:0]    w_first_ch, w_next_ch;
    logic              w_next_vld;

    assign w_hit = bvld_q[ch_q];
    assign w_tmo = (tmo_cnt_q == 32'(TMO_CYC - 1));
    assign w_cap = w_hit ? buf_q[ch_q] : {WORD_W{FILL_BIT}};

    always_comb begin
        w_consume = '0;
        w_tmo_set = '0;
        if (st_q == ST_WAIT) begin
            if (w_hit)      w_consume[ch_q] = 1'b1;
            else if (w_tmo) w_tmo_set[ch_q] = 1'b1;
        end
        // A completing word overflows only if the old one is not leaving now.
        w_ovf_set = w_done & bvld_q & ~w_consume;
    end

    // Lowest enabled channel, and the next enabled channel above ch_q.
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_next_vld = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) w_first_ch = CHW'(i);
            if (mask_q[i] && (CHW'(i) > ch_q)) begin
                w_next_ch  = CHW'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) buf_q[i] <= '0;
            bvld_q <= '0;
            ovf_q  <= '0;
            tmo_q  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_done[i] && !w_ovf_set[i]) begin
                    buf_q[i]  <= w_word[i];
                    bvld_q[i] <= 1'b1;
                end else if (w_consume[i]) begin
                    bvld_q[i] <= 1'b0;
                end
            end
            // Clear has priority, so a set on the clearing cycle is lost.
            ovf_q <= flag_clr ? '0 : (ovf_q | w_ovf_set);
            tmo_q <= flag_clr ? '0 : (tmo_q | w_tmo_set);
        end
    end

    // Outputs are registered with the state they belong to.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_IDLE;
            data_q    <= '0;
            vld_q     <= 1'b0;
            frm_q     <= 1'b0;
            mask_q    <= '0;
            len_q     <= '0;
            widx_q    <= '0;
            ch_q      <= '0;
            tmo_cnt_q <= '0;
            word_q    <= '0;
            bcnt_q    <= '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (fire_sync) begin
                        mask_q <= ch_en;
                        len_q  <= len_pkg;
                        data_q <= HDR_BYTE;
                        vld_q  <= 1'b1;
                        frm_q  <= 1'b1;
                        st_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    vld_q <= 1'b0;
                    if (len_q == 16'd0 || mask_q == '0) begin
                        frm_q <= 1'b0;
                        st_q  <= ST_DONE;
                    end else begin
                        ch_q      <= w_first_ch;
                        widx_q    <= '0;
                        tmo_cnt_q <= '0;
                        st_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_hit || w_tmo) begin
                        data_q <= w_cap[WORD_W-1 -: 8];
                        word_q <= w_cap << 8;
                        bcnt_q <= BCW'(1);
                        vld_q  <= 1'b1;
                        st_q   <= ST_BYTE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end
                ST_BYTE: begin
                    if (bcnt_q != BCW'(NB)) begin
                        data_q <= word_q[WORD_W-1 -: 8];
                        word_q <= word_q << 8;
                        bcnt_q <= bcnt_q + 1'b1;
                    end else begin
                        vld_q     <= 1'b0;
                        tmo_cnt_q <= '0;
                        if (w_next_vld) begin
                            ch_q <= w_next_ch;
                            st_q <= ST_WAIT;
                        end else begin
                            ch_q   <= w_first_ch;
                            widx_q <= widx_q + 16'd1;
                            if (widx_q + 16'd1 == len_q) begin
                                frm_q <= 1'b0;
                                st_q  <= ST_DONE;
                            end else begin
                                st_q  <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_DONE: st_q <= ST_IDLE;
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign pkg_data = data_q;
    assign pkg_vld  = vld_q;
    assign pkg_frm  = frm_q;
    assign ovf_flag = ovf_q;
    assign tmo_flag = tmo_q;

endmodule
`default_nettype wire
